// File: rtl/v_lane_seq_if.sv
// v_lane_seq bus: operation request, operand groups, lane issue
// and result buffer between the register read path and v_alu/v_mul.
interface v_lane_seq_if;
  logic         start;
  logic         ready;
  logic         op_sel;
  logic [5:0]   op_instr;
  logic [2:0]   vsew;
  logic [6:0]   vl;
  logic [127:0] op_A_1;
  logic [127:0] op_A_2;
  logic [127:0] op_A_3;
  logic [127:0] op_A_4;
  logic [127:0] op_B_1;
  logic [127:0] op_B_2;
  logic [127:0] op_B_3;
  logic [127:0] op_B_4;
  logic [5:0]   alu_op_instr;
  logic [5:0]   mul_op_instr;
  logic [2:0]   sew_out;
  logic [31:0]  op_A;
  logic [31:0]  op_B;
  logic         issue_valid;
  logic [31:0]  result_valu;
  logic [31:0]  result_vmul;
  logic [127:0] result_1;
  logic [127:0] result_2;
  logic [127:0] result_3;
  logic [127:0] result_4;
  logic         done;
  logic         err;
  logic         busy;

  modport master (
    output start, op_sel, op_instr, vsew, vl,
    output op_A_1, op_A_2, op_A_3, op_A_4,
    output op_B_1, op_B_2, op_B_3, op_B_4,
    output result_valu, result_vmul,
    input  ready, alu_op_instr, mul_op_instr, sew_out,
    input  op_A, op_B, issue_valid,
    input  result_1, result_2, result_3, result_4,
    input  done, err, busy
  );

  modport slave (
    input  start, op_sel, op_instr, vsew, vl,
    input  op_A_1, op_A_2, op_A_3, op_A_4,
    input  op_B_1, op_B_2, op_B_3, op_B_4,
    input  result_valu, result_vmul,
    output ready, alu_op_instr, mul_op_instr, sew_out,
    output op_A, op_B, issue_valid,
    output result_1, result_2, result_3, result_4,
    output done, err, busy
  );
endinterface

// File: rtl/v_lane_seq.sv
// Vector lane sequencer: latches a 16-word operation, issues one
// word pair per cycle to ALU or MUL and gathers the lane results.
module v_lane_seq #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input logic         clk,
  input logic         nrst,
  v_lane_seq_if.slave bus
);
  localparam int DEPTH =
    (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t       state;
  logic         sel_q;
  logic [511:0] a_q, b_q, res_q;
  logic [4:0]   n_q;
  logic [3:0]   iss_idx;
  logic [DEPTH-1:0] vld;
  logic [3:0]   sidx [DEPTH];

  logic [511:0] a_in, b_in;
  logic [6:0]   vl_c;
  logic [7:0]   vl_s;
  logic [4:0]   n_w;
  logic         rsv;
  logic [3:0]   nxt_idx;
  logic [8:0]   nxt_off, cap_off;
  logic         last_iss, last_cap;
  logic         cap_v;
  logic [3:0]   cap_i;
  logic [31:0]  cap_d;

  assign a_in = {bus.op_A_4, bus.op_A_3, bus.op_A_2, bus.op_A_1};
  assign b_in = {bus.op_B_4, bus.op_B_3, bus.op_B_2, bus.op_B_1};
  assign {bus.result_4, bus.result_3, bus.result_2, bus.result_1} = res_q;

  // Word count from vl clamped to VLMAX for the requested element width
  always_comb begin
    rsv  = (bus.vsew > 3'd2);
    vl_c = 7'd0;
    vl_s = 8'd0;
    n_w  = 5'd0;
    unique case (1'b1)
      (bus.vsew == 3'd0): begin
        vl_c = (bus.vl > 7'd64) ? 7'd64 : bus.vl;
        vl_s = {1'b0, vl_c} + 8'd3;
        n_w  = 5'(vl_s >> 2);
      end
      (bus.vsew == 3'd1): begin
        vl_c = (bus.vl > 7'd32) ? 7'd32 : bus.vl;
        vl_s = {1'b0, vl_c} + 8'd1;
        n_w  = 5'(vl_s >> 1);
      end
      default: begin
        vl_c = (bus.vl > 7'd16) ? 7'd16 : bus.vl;
        n_w  = 5'(vl_c);
      end
    endcase
  end

  // Capture tap sits at the selected unit's latency in the valid pipe
  always_comb begin
    cap_v    = sel_q ? vld[MUL_LAT-1]  : vld[ALU_LAT-1];
    cap_i    = sel_q ? sidx[MUL_LAT-1] : sidx[ALU_LAT-1];
    cap_d    = sel_q ? bus.result_vmul : bus.result_valu;
    cap_off  = {cap_i, 5'd0};
    nxt_idx  = iss_idx + 4'd1;
    nxt_off  = {nxt_idx, 5'd0};
    last_iss = ({1'b0, iss_idx} + 5'd1 == n_q);
    last_cap = cap_v && ({1'b0, cap_i} + 5'd1 == n_q);
  end

  // Sequencer FSM with registered outputs and result gathering
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= S_IDLE;
      sel_q            <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      res_q            <= '0;
      n_q              <= '0;
      iss_idx          <= '0;
      vld              <= '0;
      for (int k = 0; k < DEPTH; k++) sidx[k] <= '0;
      bus.ready        <= 1'b1;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      bus.alu_op_instr <= '0;
      bus.mul_op_instr <= '0;
      bus.sew_out      <= '0;
      bus.op_A         <= '0;
      bus.op_B         <= '0;
      bus.issue_valid  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      vld[0]   <= bus.issue_valid;
      sidx[0]  <= iss_idx;
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld[k]  <= vld[k-1];
        sidx[k] <= sidx[k-1];
      end
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            sel_q            <= bus.op_sel;
            a_q              <= a_in;
            b_q              <= b_in;
            n_q              <= n_w;
            iss_idx          <= '0;
            vld              <= '0;
            res_q            <= '0;
            bus.sew_out      <= bus.vsew;
            bus.ready        <= 1'b0;
            bus.busy         <= 1'b1;
            bus.alu_op_instr <= bus.op_sel ? 6'd0 : bus.op_instr;
            bus.mul_op_instr <= bus.op_sel ? bus.op_instr : 6'd0;
            if (rsv || n_w == 5'd0) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.err  <= rsv;
            end else begin
              state           <= S_ISSUE;
              bus.issue_valid <= 1'b1;
              bus.op_A        <= a_in[31:0];
              bus.op_B        <= b_in[31:0];
            end
          end
        end
        S_ISSUE: begin
          if (cap_v) res_q[cap_off +: 32] <= cap_d;
          if (last_iss) begin
            state           <= S_DRAIN;
            bus.issue_valid <= 1'b0;
            bus.op_A        <= '0;
            bus.op_B        <= '0;
          end else begin
            iss_idx  <= nxt_idx;
            bus.op_A <= a_q[nxt_off +: 32];
            bus.op_B <= b_q[nxt_off +: 32];
          end
        end
        S_DRAIN: begin
          if (cap_v) res_q[cap_off +: 32] <= cap_d;
          if (last_cap) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state            <= S_IDLE;
          bus.ready        <= 1'b1;
          bus.busy         <= 1'b0;
          bus.alu_op_instr <= '0;
          bus.mul_op_instr <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_v_lane_seq.sv
// Directed bench for v_lane_seq with simple ALU (add, lat 1)
// and MUL (multiply, lat 2) unit models.
module tb_v_lane_seq;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  v_lane_seq_if bus ();
  v_lane_seq dut (.clk(clk), .nrst(nrst), .bus(bus));

  logic [31:0] alu_p = '0, m1 = '0, m2 = '0;
  always @(posedge clk) begin
    alu_p <= bus.op_A + bus.op_B;
    m1    <= bus.op_A * bus.op_B;
    m2    <= m1;
  end
  assign bus.result_valu = alu_p;
  assign bus.result_vmul = m2;

  int n_vec = 0, n_bad = 0;
  int first_i, last_i, n_iss, done_c, n_done, rdy_c, idle_nz;
  logic err_d;
  logic [5:0] alu1, mul1;
  logic [31:0] iss_a [16];
  logic [31:0] iss_b [16];

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] res();
    return {bus.result_4, bus.result_3, bus.result_2, bus.result_1};
  endfunction

  function automatic logic [511:0] sum_pat(input logic [31:0] ab,
      input logic [31:0] bv, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = ab + i + bv;
    return r;
  endfunction

  task automatic set_ops(input logic [31:0] ab, input logic [31:0] bv);
    logic [511:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a[i*32 +: 32] = ab + i;
      b[i*32 +: 32] = bv;
    end
    {bus.op_A_4, bus.op_A_3, bus.op_A_2, bus.op_A_1} = a;
    {bus.op_B_4, bus.op_B_3, bus.op_B_2, bus.op_B_1} = b;
  endtask

  task automatic start_op(input logic sel, input logic [5:0] ins,
                          input logic [2:0] sew, input logic [6:0] vl);
    bus.op_sel   = sel;
    bus.op_instr = ins;
    bus.vsew     = sew;
    bus.vl       = vl;
    bus.start    = 1'b1;
  endtask

  task automatic run(input bit hold, input bit chg);
    first_i = -1; last_i = -1; n_iss = 0; done_c = -1;
    n_done = 0; rdy_c = -1; err_d = 1'b0; idle_nz = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      if (chg && c == 3) set_ops(32'h9000, 32'h2);
      if (c == 1) begin
        alu1 = bus.alu_op_instr;
        mul1 = bus.mul_op_instr;
      end
      if (bus.issue_valid) begin
        if (first_i < 0) first_i = c;
        last_i = c;
        if (n_iss < 16) begin
          iss_a[n_iss] = bus.op_A;
          iss_b[n_iss] = bus.op_B;
        end
        n_iss++;
      end else if ((bus.op_A | bus.op_B) != 0) idle_nz++;
      if (bus.done) begin
        n_done++;
        done_c = c;
        err_d  = bus.err;
      end
      if (bus.ready && done_c >= 0) begin
        rdy_c = c;
        break;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op_sel = 1'b0; bus.op_instr = '0;
    bus.vsew = '0; bus.vl = '0;
    set_ops(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outs", {bus.done, bus.err, bus.issue_valid,
        bus.op_A, bus.op_B, bus.alu_op_instr, bus.mul_op_instr}, 0);
    chk("rst_res", res(), 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // ALU e32 full
    set_ops(32'h0, 32'h100);
    start_op(1'b0, 6'h11, 3'd2, 7'd16);
    run(0, 0);
    chk("alu_first", first_i, 1);
    chk("alu_last", last_i, 16);
    chk("alu_niss", n_iss, 16);
    chk("alu_done", done_c, 18);
    chk("alu_err", err_d, 0);
    chk("alu_ready", rdy_c, 19);
    chk("alu_res", res(), sum_pat(32'h0, 32'h100, 16));
    chk("alu_opc", {alu1, mul1}, {6'h11, 6'h00});
    chk("alu_idle0", idle_nz, 0);

    // MUL e8 partial
    set_ops(32'h3, 32'h5);
    start_op(1'b1, 6'h2A, 3'd0, 7'd5);
    run(0, 0);
    chk("mul_first", first_i, 1);
    chk("mul_last", last_i, 2);
    chk("mul_done", done_c, 5);
    chk("mul_ready", rdy_c, 6);
    chk("mul_res", res(), {448'h0, 32'd20, 32'd15});
    chk("mul_opc", {alu1, mul1}, {6'h00, 6'h2A});

    // vl = 0
    start_op(1'b0, 6'h01, 3'd2, 7'd0);
    run(0, 0);
    chk("vl0_done", done_c, 1);
    chk("vl0_err", err_d, 0);
    chk("vl0_niss", n_iss, 0);
    chk("vl0_ready", rdy_c, 2);
    chk("vl0_res", res(), 0);

    // e16 clamp: vl=100 -> 32 elements -> 16 words
    set_ops(32'h50, 32'h7);
    start_op(1'b0, 6'h03, 3'd1, 7'd100);
    run(0, 0);
    chk("clamp_niss", n_iss, 16);
    chk("clamp_done", done_c, 18);
    chk("clamp_res", res(), sum_pat(32'h50, 32'h7, 16));

    // reserved vsew
    start_op(1'b0, 6'h05, 3'b011, 7'd16);
    run(0, 0);
    chk("rsv_done", done_c, 1);
    chk("rsv_err", err_d, 1);
    chk("rsv_niss", n_iss, 0);
    chk("rsv_res", res(), 0);

    // start held while busy, operands changed mid-op
    set_ops(32'h1000, 32'h1);
    start_op(1'b0, 6'h11, 3'd2, 7'd16);
    run(1, 1);
    chk("hold_ndone", n_done, 1);
    chk("hold_done", done_c, 18);
    chk("hold_ready", rdy_c, 19);
    chk("hold_iss5", {iss_a[5], iss_b[5]}, {32'h1005, 32'h1});
    chk("hold_res", res(), sum_pat(32'h1000, 32'h1, 16));
    run(0, 0);
    chk("hold2_first", first_i, 1);
    chk("hold2_done", done_c, 18);
    chk("hold2_res", res(), sum_pat(32'h9000, 32'h2, 16));

    // reset in DRAIN (cycle 17)
    set_ops(32'h20, 32'h3);
    start_op(1'b0, 6'h11, 3'd2, 7'd16);
    n_done = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) n_done++;
    end
    @(posedge clk); #1;
    chk("rst17_busy_pre", bus.busy, 1);
    nrst = 1'b0;
    #1;
    chk("rst17_ready", bus.ready, 1);
    chk("rst17_busy", bus.busy, 0);
    chk("rst17_outs", {bus.done, bus.err, bus.issue_valid,
        bus.op_A, bus.op_B, bus.alu_op_instr, bus.sew_out}, 0);
    chk("rst17_res", res(), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    chk("rst17_nodone", n_done, 0);
    set_ops(32'h0, 32'h100);
    start_op(1'b0, 6'h11, 3'd2, 7'd16);
    run(0, 0);
    chk("post_done", done_c, 18);
    chk("post_res", res(), sum_pat(32'h0, 32'h100, 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/v_lane_seq.md
# v_lane_seq

Vector lane sequencer between the vector register read path and the v_alu/v_mul lane datapath. It accepts one vector operation per start handshake and latches the full 512-bit A and B operand groups. It then issues one 32-bit word pair per cycle to the selected unit (ALU or MUL), collects the unit results into a 512-bit result buffer, and pulses `done` when the last result is captured.

## Interface
Parameters:
- `ALU_LAT`, default 1: cycles from a word issue to the valid `result_valu` sample.
- `MUL_LAT`, default 2: cycles from a word issue to the valid `result_vmul` sample.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only while `ready`=1.
- `ready`  out  1  high in IDLE only.
- `op_sel`  in  1  0 = ALU, 1 = MUL; sampled at accept.
- `op_instr`  in  6  unit opcode; sampled at accept.
- `vsew`  in  3  000=e8, 001=e16, 010=e32, others reserved; sampled at accept.
- `vl`  in  7  element count; sampled at accept.
- `op_A_1`..`op_A_4`  in  128 each  A operand group; `op_A_1` bits [31:0] = word 0, `op_A_4` [127:96] = word 15.
- `op_B_1`..`op_B_4`  in  128 each  B operand group, same packing.
- `alu_op_instr`  out  6  ALU opcode.
- `mul_op_instr`  out  6  MUL opcode.
- `sew_out`  out  3  latched `vsew` to both units.
- `op_A`  out  32  issued A word (registered).
- `op_B`  out  32  issued B word (registered).
- `issue_valid`  out  1  high in every cycle a word is on `op_A`/`op_B`.
- `result_valu`  in  32  ALU result.
- `result_vmul`  in  32  MUL result.
- `result_1`..`result_4`  out  128 each  result buffer, same packing as operands.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = reserved `vsew`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE → accept.** `start` && `ready` latches all operands and controls and clears the result buffer to 0.
  - Word count N = ceil(min(vl, VLMAX) << vsew / 4), with VLMAX = 64 / 32 / 16 for e8 / e16 / e32.
  - N = 0 (vl = 0), or reserved `vsew`, goes directly to DONE. Reserved `vsew` also sets `err`=1.
  - Otherwise the block goes to ISSUE.
- **ISSUE.** Drives word i (i = 0..N-1) on `op_A`/`op_B` with `issue_valid`=1, one word per cycle, no bubbles. After word N-1 the block goes to DRAIN.
- **Opcode routing.** The selected unit's opcode output carries the latched `op_instr` from accept until DONE. The unselected unit's opcode output is 6'd0.
- **DRAIN.** A word issued in cycle t is captured from the selected unit's result at the edge ending cycle t+L, where L = `ALU_LAT` or `MUL_LAT`. It is written to result word i. A valid shift register with a per-stage index tracks issued words. The block leaves DRAIN after the capture of word N-1.
- **DONE.** Lasts one cycle: `done`=1, `busy`=1, `ready`=0. Then IDLE.
- Result words ≥ N stay 0. Sub-word tail bytes of word N-1 are stored as the unit returned them; no masking.
- `start` while not `ready` is ignored and does not queue.
- **Reset values.** All outputs 0, except `ready`=1. Result buffer and latched operands clear to 0.
- **Reset mid-operation.** Aborts immediately with no `done`. The first cycle after deassertion is IDLE.

## Timing
- Accept edge at end of cycle 0. Word i is issued in cycle 1+i.
- Last capture at the end of cycle N+L. `done` is in cycle N+L+1. `ready` is 1 again in cycle N+L+2.
- vl = 0 or reserved `vsew`: `done` in cycle 1, `ready` in cycle 2. No `issue_valid` is asserted.
- `result_*` is stable from the `done` cycle until the next accept.
- `issue_valid`, `op_A`, `op_B` are 0 in every non-issue cycle.
- Throughput is one operation per N+L+2 cycles; there is no overlap between operations.

## Test plan
- **ALU e32.** ALU, e32, vl=16, A word i = i, B word i = 0x100, ALU model returns A+B with latency 1 → `issue_valid` in cycles 1–16; `done` in cycle 18; result word i = 0x100+i; `ready` in cycle 19.
- **MUL e8 partial.** MUL, e8, vl=5, ALU_LAT=1, MUL_LAT=2 → N=2, issues in cycles 1–2, `done` in cycle 5; words 2–15 = 0; `alu_op_instr`=0 throughout.
- **Empty and clamp.** vl=0 → `done` in cycle 1, `err`=0, no issue. Then e16, vl=100 → clamped to 32 elements, N=16.
- **Reserved `vsew`.** `vsew`=3'b011 → `done`+`err` in cycle 1, no issue, result all 0.
- **Start while busy.** `start` asserted continuously from cycle 0 → second accept only in the first `ready` cycle after `done`; operands changed mid-operation do not alter issued words.
- **Reset mid-DRAIN.** `nrst` low in cycle 17 of an ALU e32 vl=16 run → all outputs at reset values asynchronously; no `done` pulse; new `start` after release proceeds normally.
